// File: rtl/io_seq_pkg.sv
// Shared types and constants for the picoMips I/O sequencer.
// The optional result watchdog is enabled by defining IO_SEQ_WDOG_EN.
package io_seq_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam logic [7:0] LED_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        S_X_ARM,
        S_X_REL,
        S_Y_ARM,
        S_Y_REL,
        S_ISSUE,
        S_WAIT_RES,
        S_SHOW_X,
        S_SHOW_Y
    } state_t;

endpackage

// File: rtl/sw_debounce.sv
// Strobe conditioner: two-flop synchroniser plus a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic nReset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/io_sequencer.sv
// Front-end controller for picoMips: captures x/y from switches on debounced
// strobe presses, hands them to the datapath, then shows x2 and y2 on the LEDs.
// Optional result watchdog: define IO_SEQ_WDOG_EN.
module io_sequencer
    import io_seq_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WDOG_CYCLES     = 255
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_strobe,
    output logic [DATA_W-1:0] op_x,
    output logic [DATA_W-1:0] op_y,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic [DATA_W-1:0] res_x,
    input  logic [DATA_W-1:0] res_y,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              wdog_err
);

    if (DEBOUNCE_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("io_sequencer: DEBOUNCE_CYCLES and WDOG_CYCLES must be >= 1");
    end

    logic level;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .Clock (Clock),
        .nReset(nReset),
        .raw   (sw_strobe),
        .level (level)
    );

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_x_q, op_x_d;
    logic [DATA_W-1:0] op_y_q, op_y_d;
    logic [DATA_W-1:0] res_y_q, res_y_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              op_valid_q, op_valid_d;
    logic              res_ready_q, res_ready_d;
    logic              busy_q, busy_d;

`ifdef IO_SEQ_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
`endif

    always_comb begin
        // NOTE: every _d gets a hold-value default first so no path infers a latch.
        state_d = state_q;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;
        res_y_d = res_y_q;
        led_d   = led_q;
`ifdef IO_SEQ_WDOG_EN
        wdog_err_d = wdog_err_q;
        wdog_cnt_d = (state_q == S_WAIT_RES) ? wdog_cnt_q + WDOG_W'(1) : '0;
`endif

        case (state_q)
            S_X_ARM: begin
                if (level) begin
                    op_x_d  = sw_data;
                    state_d = S_X_REL;
                end
            end
            S_X_REL: begin
                if (!level) state_d = S_Y_ARM;
            end
            S_Y_ARM: begin
                if (level) begin
                    op_y_d  = sw_data;
                    state_d = S_Y_REL;
                end
            end
            S_Y_REL: begin
                if (!level) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_valid_q && op_ready) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // A result on the timeout cycle takes priority over the watchdog.
                if (res_valid && res_ready_q) begin
                    res_y_d = res_y;
                    led_d   = res_x;
                    state_d = S_SHOW_X;
                end
`ifdef IO_SEQ_WDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    wdog_err_d = 1'b1;
                    led_d      = DATA_W'(LED_TIMEOUT);
                    state_d    = S_SHOW_Y;
                end
`endif
            end
            S_SHOW_X: begin
                if (level) begin
                    led_d   = res_y_q;
                    state_d = S_SHOW_Y;
                end
            end
            S_SHOW_Y: begin
                if (!level) state_d = S_X_ARM;
            end
            default: state_d = S_X_ARM;
        endcase

        // Handshake outputs are decoded from the next state so they are
        // registered yet valid from the first cycle in the state.
        op_valid_d  = (state_d == S_ISSUE);
        res_ready_d = (state_d == S_WAIT_RES);
        busy_d      = op_valid_d | res_ready_d;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_X_ARM;
            op_x_q      <= '0;
            op_y_q      <= '0;
            res_y_q     <= '0;
            led_q       <= '0;
            op_valid_q  <= 1'b0;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            res_y_q     <= res_y_d;
            led_q       <= led_d;
            op_valid_q  <= op_valid_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef IO_SEQ_WDOG_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

    assign op_x      = op_x_q;
    assign op_y      = op_y_q;
    assign op_valid  = op_valid_q;
    assign res_ready = res_ready_q;
    assign led       = led_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer (DEBOUNCE_CYCLES=4, WDOG_CYCLES=16).
// Watchdog scenario is compiled in when IO_SEQ_WDOG_EN is defined.
module tb_io_sequencer;

    logic       Clock;
    logic       nReset;
    logic [7:0] sw_data;
    logic       sw_strobe;
    logic [7:0] op_x, op_y;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] res_x, res_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] led;
    logic       busy;
    logic       wdog_err;

    int checks = 0;
    int errors = 0;

    io_sequencer #(
        .DATA_W         (8),
        .DEBOUNCE_CYCLES(4),
        .WDOG_CYCLES    (16)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .sw_data  (sw_data),
        .sw_strobe(sw_strobe),
        .op_x     (op_x),
        .op_y     (op_y),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .res_x    (res_x),
        .res_y    (res_y),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .led      (led),
        .busy     (busy),
        .wdog_err (wdog_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_reset();
        nReset    = 1'b0;
        sw_strobe = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        tick(2);
        nReset = 1'b1;
        tick(1);
    endtask

    // Long, clean press: level rises 6 cycles after raw and falls 6 after release.
    task automatic press(input logic [7:0] d);
        sw_data   = d;
        sw_strobe = 1'b1;
        tick(8);
        sw_strobe = 1'b0;
        tick(8);
    endtask

    task automatic wait_op_valid(input string name);
        int n = 0;
        while (op_valid !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        checks++;
        if (op_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s op_valid_timeout got %b want 1", name, op_valid);
        end
    endtask

    task automatic test_reset();
        nReset    = 1'b0;
        sw_data   = 8'h5A;
        sw_strobe = 1'b0;
        op_ready  = 1'b0;
        res_x     = 8'h00;
        res_y     = 8'h00;
        res_valid = 1'b0;
        tick(2);
        checks++;
        if ({op_x, op_y, led} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 000000", {op_x, op_y, led});
        end
        checks++;
        if ({op_valid, res_ready, busy, wdog_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {op_valid, res_ready, busy, wdog_err});
        end
        nReset = 1'b1;
        tick(1);
    endtask

    task automatic test_debounce();
        do_reset();
        sw_data   = 8'hAA;
        sw_strobe = 1'b1;
        tick(3);
        sw_strobe = 1'b0;
        tick(10);
        checks++;
        if (op_x !== 8'h00) begin
            errors++;
            $display("FAIL deb_glitch3 op_x got %h want 00", op_x);
        end
        sw_strobe = 1'b1;
        tick(4);
        sw_strobe = 1'b0;
        tick(2);
        checks++;
        if (op_x !== 8'h00) begin
            errors++;
            $display("FAIL deb_early op_x got %h want 00", op_x);
        end
        tick(1);
        checks++;
        if (op_x !== 8'hAA) begin
            errors++;
            $display("FAIL deb_pulse4 op_x got %h want aa", op_x);
        end
        tick(10);
        press(8'h55);
        wait_op_valid("deb_y");
        checks++;
        if (op_y !== 8'h55) begin
            errors++;
            $display("FAIL deb_y op_y got %h want 55", op_y);
        end
    endtask

    task automatic test_full_pass();
        do_reset();
        press(8'h10);
        checks++;
        if (op_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_no_issue_after_x got %b want 0", op_valid);
        end
        press(8'h08);
        wait_op_valid("pass");
        checks++;
        if ({op_x, op_y} !== 16'h1008) begin
            errors++;
            $display("FAIL pass_operands got %h want 1008", {op_x, op_y});
        end
        checks++;
        if ({busy, res_ready} !== 2'b10) begin
            errors++;
            $display("FAIL pass_issue_ctrl got %b want 10", {busy, res_ready});
        end
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        checks++;
        if ({op_valid, res_ready, busy} !== 3'b011) begin
            errors++;
            $display("FAIL pass_wait_ctrl got %b want 011", {op_valid, res_ready, busy});
        end
        tick(3);
        checks++;
        if ({res_ready, led} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL pass_wait_hold got %h want 100", {res_ready, led});
        end
        res_x     = 8'h24;
        res_y     = 8'hEA;
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        checks++;
        if ({led, res_ready, busy} !== {8'h24, 2'b00}) begin
            errors++;
            $display("FAIL pass_led_x2 got %h want 090", {led, res_ready, busy});
        end
        sw_strobe = 1'b1;
        tick(6);
        checks++;
        if (led !== 8'h24) begin
            errors++;
            $display("FAIL pass_led_hold got %h want 24", led);
        end
        tick(1);
        checks++;
        if (led !== 8'hEA) begin
            errors++;
            $display("FAIL pass_led_y2 got %h want ea", led);
        end
        sw_strobe = 1'b0;
        tick(8);
        press(8'h11);
        checks++;
        if ({op_x, led} !== 16'h11EA) begin
            errors++;
            $display("FAIL pass_rearm got %h want 11ea", {op_x, led});
        end
    endtask

    // Continues from test_full_pass: result already waiting when the op is accepted.
    task automatic test_back_to_back();
        press(8'h22);
        wait_op_valid("b2b");
        res_x     = 8'h81;
        res_y     = 8'h18;
        res_valid = 1'b1;
        op_ready  = 1'b1;
        tick(1);
        op_ready = 1'b0;
        checks++;
        if ({res_ready, led} !== {1'b1, 8'hEA}) begin
            errors++;
            $display("FAIL b2b_entry got %h want 1ea", {res_ready, led});
        end
        tick(1);
        res_valid = 1'b0;
        checks++;
        if ({res_ready, led} !== {1'b0, 8'h81}) begin
            errors++;
            $display("FAIL b2b_capture got %h want 081", {res_ready, led});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        press(8'h3C);
        press(8'hC3);
        wait_op_valid("bp");
        for (int i = 0; i < 10; i++) begin
            sw_data = 8'(i * 17 + 1);
            tick(1);
            checks++;
            if ({op_valid, op_x, op_y} !== {1'b1, 16'h3CC3}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got %h want 13cc3", i, {op_valid, op_x, op_y});
            end
        end
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        checks++;
        if ({op_valid, res_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_accept got %b want 01", {op_valid, res_ready});
        end
    endtask

    task automatic test_early_level();
        do_reset();
        press(8'h01);
        press(8'h02);
        wait_op_valid("early");
        op_ready = 1'b1;
        tick(1);
        op_ready  = 1'b0;
        sw_strobe = 1'b1;
        tick(8);
        checks++;
        if ({busy, res_ready, led} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL early_wait got %h want 300", {busy, res_ready, led});
        end
        res_x     = 8'h5A;
        res_y     = 8'hA5;
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        checks++;
        if (led !== 8'h5A) begin
            errors++;
            $display("FAIL early_x2 got %h want 5a", led);
        end
        tick(1);
        checks++;
        if (led !== 8'hA5) begin
            errors++;
            $display("FAIL early_y2 got %h want a5", led);
        end
        sw_strobe = 1'b0;
        tick(8);
        press(8'h77);
        checks++;
        if ({op_x, led} !== 16'h77A5) begin
            errors++;
            $display("FAIL early_rearm got %h want 77a5", {op_x, led});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(8'h12);
        press(8'h34);
        wait_op_valid("mid_first");
        op_ready = 1'b1;
        tick(1);
        op_ready  = 1'b0;
        res_x     = 8'hC0;
        res_y     = 8'hD0;
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        press(8'h00);
        press(8'h56);
        press(8'h78);
        wait_op_valid("mid_second");
        checks++;
        if ({op_x, op_y, led} !== 24'h5678D0) begin
            errors++;
            $display("FAIL mid_setup got %h want 5678d0", {op_x, op_y, led});
        end
        nReset = 1'b0;
        #1;
        checks++;
        if ({op_x, op_y, led} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_data got %h want 000000", {op_x, op_y, led});
        end
        checks++;
        if ({op_valid, res_ready, busy, wdog_err} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_ctrl got %b want 0000", {op_valid, res_ready, busy, wdog_err});
        end
        op_ready = 1'b1;
        tick(2);
        nReset = 1'b1;
        tick(3);
        op_ready = 1'b0;
        checks++;
        if ({op_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL mid_after got %b want 00", {op_valid, busy});
        end
        press(8'h9C);
        checks++;
        if (op_x !== 8'h9C) begin
            errors++;
            $display("FAIL mid_rearm op_x got %h want 9c", op_x);
        end
    endtask

`ifdef IO_SEQ_WDOG_EN
    task automatic test_wdog();
        do_reset();
        press(8'h0F);
        press(8'hF0);
        wait_op_valid("wdog");
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        tick(15);
        checks++;
        if ({wdog_err, res_ready, led} !== {2'b01, 8'h00}) begin
            errors++;
            $display("FAIL wdog_before got %h want 100", {wdog_err, res_ready, led});
        end
        tick(1);
        checks++;
        if ({wdog_err, res_ready, busy, led} !== {3'b100, 8'hFF}) begin
            errors++;
            $display("FAIL wdog_fire got %h want 4ff", {wdog_err, res_ready, busy, led});
        end
        tick(2);
        press(8'h9A);
        checks++;
        if ({wdog_err, op_x, led} !== {1'b1, 16'h9AFF}) begin
            errors++;
            $display("FAIL wdog_rearm got %h want 19aff", {wdog_err, op_x, led});
        end
    endtask
`else
    task automatic test_no_wdog();
        do_reset();
        press(8'h0F);
        press(8'hF0);
        wait_op_valid("nowdog");
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        tick(300);
        checks++;
        if ({wdog_err, res_ready, busy, led} !== {3'b011, 8'h00}) begin
            errors++;
            $display("FAIL nowdog_wait got %h want 300", {wdog_err, res_ready, busy, led});
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_debounce();
        test_full_pass();
        test_back_to_back();
        test_backpressure();
        test_early_level();
        test_reset_mid();
`ifdef IO_SEQ_WDOG_EN
        test_wdog();
`else
        test_no_wdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
